// File: rtl/pc_npc_unit_pkg.sv
// Shared constants for the PC/nPC front end.
// Select encodings and default address geometry.
package pc_npc_unit_pkg;

  localparam int WIDTH = 32;
  localparam int INC   = 4;

  localparam logic [1:0] SEL_SEQ      = 2'b00;
  localparam logic [1:0] SEL_BRANCH   = 2'b01;
  localparam logic [1:0] SEL_JUMP     = 2'b10;
  localparam logic [1:0] SEL_REDIRECT = 2'b11;

endpackage

// File: rtl/pc_npc_unit_pc_adder.sv
// Combinational fixed-step address incrementer.
// Wraps modulo 2^WIDTH with no carry out.
module pc_adder #(
  parameter int WIDTH = 32,
  parameter int INC   = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = a + WIDTH'(INC);

endmodule

// File: rtl/pc_npc_unit.sv
// PC/nPC register pair with delayed-branch next-address selection.
// Drives the fetch address and the link value pc+INC.
module pc_npc_unit
  import pc_npc_unit_pkg::*;
#(
  parameter int               WIDTH    = pc_npc_unit_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               INC      = pc_npc_unit_pkg::INC
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             le,
  input  logic [1:0]       mux_select,
  input  logic [WIDTH-1:0] ta,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic [WIDTH-1:0] pc_plus4
);

  localparam logic [WIDTH-1:0] RESET_NPC =
    RESET_PC + WIDTH'(INC);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] npc_q;
  logic [WIDTH-1:0] npc_seq;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] tgt_inc;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] npc_d;

  pc_adder #(.WIDTH(WIDTH), .INC(INC)) u_seq_add (
    .a (npc_q),
    .y (npc_seq)
  );

  pc_adder #(.WIDTH(WIDTH), .INC(INC)) u_tgt_add (
    .a (tgt),
    .y (tgt_inc)
  );

  pc_adder #(.WIDTH(WIDTH), .INC(INC)) u_pc_add (
    .a (pc_q),
    .y (pc_plus4)
  );

  // jump takes the ALU result, redirect takes ta
  assign tgt = (mux_select == SEL_JUMP) ? alu_out : ta;

  always_comb begin
    pc_d  = npc_q;
    npc_d = npc_seq;
    case (mux_select)
      SEL_BRANCH: begin
        pc_d  = npc_q;
        npc_d = ta;
      end
      SEL_JUMP,
      SEL_REDIRECT: begin
        pc_d  = tgt;
        npc_d = tgt_inc;
      end
      default: begin
        pc_d  = npc_q;
        npc_d = npc_seq;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q  <= RESET_PC;
      npc_q <= RESET_NPC;
    end else if (le) begin
      pc_q  <= pc_d;
      npc_q <= npc_d;
    end
  end

  assign pc  = pc_q;
  assign npc = npc_q;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Directed bench for pc_npc_unit.
// Hand-computed pc/npc/pc_plus4 after each edge.
module tb_pc_npc_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        le;
  logic [1:0]  mux_select;
  logic [31:0] ta;
  logic [31:0] alu_out;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] pc_plus4;

  int n_checks = 0;
  int n_fails  = 0;

  pc_npc_unit dut (
    .clk        (clk),
    .clr        (clr),
    .le         (le),
    .mux_select (mux_select),
    .ta         (ta),
    .alu_out    (alu_out),
    .pc         (pc),
    .npc        (npc),
    .pc_plus4   (pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag,
                      input logic [31:0] epc,
                      input logic [31:0] enpc,
                      input logic [31:0] ep4);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".npc"}, npc, enpc);
    chk({tag, ".pc_plus4"}, pc_plus4, ep4);
  endtask

  initial begin
    clr = 1'b1;
    le = 1'b0;
    mux_select = 2'b00;
    ta = 32'h0;
    alu_out = 32'h0;
    step();
    chk3("reset", 32'h0, 32'h4, 32'h4);

    clr = 1'b0;
    le = 1'b1;
    step();
    chk3("seq1", 32'h4, 32'h8, 32'h8);
    step();
    chk3("seq2", 32'h8, 32'hC, 32'hC);

    le = 1'b0;
    mux_select = 2'b01;
    ta = 32'h100;
    step();
    chk3("hold1", 32'h8, 32'hC, 32'hC);
    step();
    chk3("hold2", 32'h8, 32'hC, 32'hC);
    step();
    chk3("hold3", 32'h8, 32'hC, 32'hC);

    le = 1'b1;
    mux_select = 2'b00;
    step();
    chk3("seq3", 32'hC, 32'h10, 32'h10);

    mux_select = 2'b01;
    ta = 32'h200;
    step();
    chk3("branch", 32'h10, 32'h200, 32'h14);
    mux_select = 2'b00;
    ta = 32'h999;
    step();
    chk3("branch_slot", 32'h200, 32'h204, 32'h204);

    mux_select = 2'b10;
    alu_out = 32'h40;
    step();
    chk3("jump", 32'h40, 32'h44, 32'h44);
    mux_select = 2'b11;
    ta = 32'h80;
    alu_out = 32'h5555;
    step();
    chk3("redirect", 32'h80, 32'h84, 32'h84);

    mux_select = 2'b10;
    alu_out = 32'hFFFF_FFFC;
    step();
    chk3("wrap", 32'hFFFF_FFFC, 32'h0, 32'h0);
    mux_select = 2'b00;
    step();
    chk3("wrap_seq", 32'h0, 32'h4, 32'h4);

    mux_select = 2'b11;
    ta = 32'h80;
    step();
    chk3("pre_clr1", 32'h80, 32'h84, 32'h84);
    clr = 1'b1;
    mux_select = 2'b01;
    ta = 32'h300;
    step();
    chk3("clr_le1", 32'h0, 32'h4, 32'h4);

    clr = 1'b0;
    mux_select = 2'b11;
    ta = 32'h80;
    step();
    chk3("pre_clr2", 32'h80, 32'h84, 32'h84);
    clr = 1'b1;
    le = 1'b0;
    step();
    chk3("clr_le0", 32'h0, 32'h4, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
